// File: rtl/hybrid_control_pipe.sv
// Pipelined hybrid switching controller: jump-set evaluation on (z1, z2), sigma decision
// with stale-sample blanking, minimum-dwell timer and dead-time complementary gate drive.
module hybrid_control_pipe #(
    parameter int DW       = 14,
    parameter int TW       = 16,
    parameter int MUW      = 8,
    parameter int MU_Z1    = 110,
    parameter int MU_Z2    = 121,
    parameter int VGW      = 24,
    parameter int CNTW     = 16,
    parameter int DEADTIME = 10
) (
    input  logic                   i_clock,
    input  logic                   i_RESET,
    input  logic signed [DW-1:0]   i_vC,
    input  logic signed [DW-1:0]   i_iC,
    input  logic signed [TW-1:0]   i_sin,
    input  logic signed [TW-1:0]   i_cos,
    input  logic signed [VGW-1:0]  i_Vg,
    input  logic        [1:0]      i_mode,
    input  logic        [CNTW-1:0] i_delay,
    output logic                   o_sigma,
    output logic                   o_gate_a,
    output logic                   o_gate_b,
    output logic                   o_hold,
    output logic        [15:0]     o_njump
);
    localparam int ZW0 = DW + MUW + 1;
    localparam int ZW  = ((ZW0 > VGW) ? ZW0 : VGW) + 1;
    localparam int PW  = ZW + TW;
    localparam int JW  = ZW + TW + 1;
    localparam int DTW = $clog2(DEADTIME + 1);

    localparam logic signed [ZW-1:0] MU1     = ZW'(MU_Z1);
    localparam logic signed [ZW-1:0] MU2     = ZW'(MU_Z2);
    localparam logic        [DTW-1:0] DT_LOAD = DTW'(DEADTIME);

    typedef enum logic [1:0] {
        MODE_HALF    = 2'b00,
        MODE_QUARTER = 2'b01,
        MODE_DWELL   = 2'b10,
        MODE_SAFE    = 2'b11
    } mode_e;

    mode_e mode;

    logic signed [ZW-1:0] vc_ext, ic_ext, vg_ext;
    logic signed [PW-1:0] z1_ext, z2_ext, sin_ext, cos_ext;
    logic signed [JW-1:0] p1_ext, p2_ext, p3_ext, p4_ext;

    logic signed [ZW-1:0] z1_q, z1_d, z2_q, z2_d;
    logic signed [PW-1:0] p1_q, p1_d, p2_q, p2_d, p3_q, p3_d, p4_q, p4_d;
    logic signed [JW-1:0] j_q, j_d, j2_q, j2_d;
    logic                 tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
    logic                 sigma_q, sigma_d;
    logic [CNTW-1:0]      dwell_q, dwell_d;
    logic [15:0]          njump_q, njump_d;
    logic [DTW-1:0]       dt_q, dt_d;
    logic                 gate_a_q, gate_a_d, gate_b_q, gate_b_d;

    logic sample_valid, toggle;
    logic j_neg, j_pos, j2_neg, j2_pos, sj_neg, sj2_neg;

    assign mode    = mode_e'(i_mode);
    assign vc_ext  = {{(ZW-DW){i_vC[DW-1]}}, i_vC};
    assign ic_ext  = {{(ZW-DW){i_iC[DW-1]}}, i_iC};
    assign vg_ext  = {{(ZW-VGW){i_Vg[VGW-1]}}, i_Vg};
    assign z1_ext  = {{TW{z1_q[ZW-1]}}, z1_q};
    assign z2_ext  = {{TW{z2_q[ZW-1]}}, z2_q};
    assign sin_ext = {{ZW{i_sin[TW-1]}}, i_sin};
    assign cos_ext = {{ZW{i_cos[TW-1]}}, i_cos};
    assign p1_ext  = {p1_q[PW-1], p1_q};
    assign p2_ext  = {p2_q[PW-1], p2_q};
    assign p3_ext  = {p3_q[PW-1], p3_q};
    assign p4_ext  = {p4_q[PW-1], p4_q};

    // Arithmetic pipeline; widths are sized so no stage can overflow.
    always_comb begin
        z1_d   = (vc_ext * MU1) + (sigma_q ? -vg_ext : vg_ext);
        z2_d   = ic_ext * MU2;
        tag1_d = sigma_q;
        p1_d   = z1_ext * sin_ext;
        p2_d   = z2_ext * cos_ext;
        p3_d   = z1_ext * cos_ext;
        p4_d   = z2_ext * sin_ext;
        tag2_d = tag1_q;
        j_d    = p1_ext + p2_ext;
        j2_d   = p4_ext - p3_ext;
        tag3_d = tag2_q;
    end

    always_comb begin
        // A sample tagged with the old sigma is stale; this also skips the 3 post-toggle slots.
        sample_valid = (tag3_q == sigma_q);
        j_neg        = j_q[JW-1];
        j_pos        = ~j_q[JW-1] & (j_q != '0);
        j2_neg       = j2_q[JW-1];
        j2_pos       = ~j2_q[JW-1] & (j2_q != '0);
        sj_neg       = sigma_q ? j_pos : j_neg;
        sj2_neg      = sigma_q ? j2_pos : j2_neg;

        sigma_d = sigma_q;
        case (mode)
            MODE_HALF:    if (sample_valid) sigma_d = j_neg;
            MODE_QUARTER: if (sample_valid && sj_neg && sj2_neg) sigma_d = ~sigma_q;
            MODE_DWELL:   if (sample_valid && (dwell_q == '0)) sigma_d = j_neg;
            MODE_SAFE:    sigma_d = 1'b1;
            default:      sigma_d = 1'b1;
        endcase
        toggle = (sigma_d != sigma_q);

        dwell_d = dwell_q;
        njump_d = njump_q;
        if (toggle) begin
            dwell_d = i_delay;
            njump_d = njump_q + 16'd1;
        end else if (dwell_q != '0) begin
            dwell_d = dwell_q - CNTW'(1);
        end

        dt_d     = dt_q;
        gate_a_d = gate_a_q;
        gate_b_d = gate_b_q;
        if (toggle) begin
            dt_d     = DT_LOAD;
            gate_a_d = 1'b0;
            gate_b_d = 1'b0;
        end else if (dt_q > DTW'(1)) begin
            dt_d     = dt_q - DTW'(1);
            gate_a_d = 1'b0;
            gate_b_d = 1'b0;
        end else if (dt_q == DTW'(1)) begin
            dt_d     = '0;
            gate_a_d = sigma_q;
            gate_b_d = ~sigma_q;
        end
    end

    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            z1_q     <= '0;
            z2_q     <= '0;
            p1_q     <= '0;
            p2_q     <= '0;
            p3_q     <= '0;
            p4_q     <= '0;
            j_q      <= '0;
            j2_q     <= '0;
            tag1_q   <= 1'b1;
            tag2_q   <= 1'b1;
            tag3_q   <= 1'b1;
            sigma_q  <= 1'b1;
            dwell_q  <= '0;
            njump_q  <= '0;
            dt_q     <= DT_LOAD;
            gate_a_q <= 1'b0;
            gate_b_q <= 1'b0;
        end else begin
            z1_q     <= z1_d;
            z2_q     <= z2_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            p3_q     <= p3_d;
            p4_q     <= p4_d;
            j_q      <= j_d;
            j2_q     <= j2_d;
            tag1_q   <= tag1_d;
            tag2_q   <= tag2_d;
            tag3_q   <= tag3_d;
            sigma_q  <= sigma_d;
            dwell_q  <= dwell_d;
            njump_q  <= njump_d;
            dt_q     <= dt_d;
            gate_a_q <= gate_a_d;
            gate_b_q <= gate_b_d;
        end
    end

    assign o_sigma  = sigma_q;
    assign o_gate_a = gate_a_q;
    assign o_gate_b = gate_b_q;
    assign o_hold   = (dwell_q != '0);
    assign o_njump  = njump_q;

endmodule
